gpio_banked: RTL and testbench

GPIO_BANKED -- requirements
Module: gpio_banked

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_bank.sv | 123 ++++++++++++
 rtl/gpio_banked.sv | 56 +++++
 tb/tb_gpio_banked.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register map and interrupt-mode encodings for the banked GPIO block.
package gpio_pkg;

  localparam logic [2:0] REG_DIR      = 3'd0;
  localparam logic [2:0] REG_OUT      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_IE       = 3'd3;
  localparam logic [2:0] REG_IP       = 3'd4;
  localparam logic [2:0] REG_IMODE_LO = 3'd5;
  localparam logic [2:0] REG_IMODE_HI = 3'd6;
  localparam logic [2:0] REG_DEBEN    = 3'd7;

  // Per-pin mode is {IMODE_HI[n], IMODE_LO[n]}.
  typedef enum logic [1:0] {
    IMODE_RISE  = 2'b00,
    IMODE_FALL  = 2'b01,
    IMODE_BOTH  = 2'b10,
    IMODE_LEVEL = 2'b11
  } imode_e;

  function automatic logic pin_event(imode_e mode, logic cur, logic prev);
    case (mode)
      IMODE_RISE:  return cur & ~prev;
      IMODE_FALL:  return ~cur & prev;
      IMODE_BOTH:  return cur ^ prev;
      IMODE_LEVEL: return cur;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_bank.sv
// One 8-pin GPIO bank: CSRs, input synchroniser, edge/level interrupt capture.
// Optional per-pin debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] reg_a,
  input  logic [7:0] di,
  input  logic [7:0] pin_in,
  output logic [7:0] rdata,
  output logic [7:0] out,
  output logic [7:0] oe,
  output logic       irq
);

  if (DEBOUNCE_DIV < 2 || DEBOUNCE_DIV > 65536) begin : g_bad_div
    $error("gpio_bank: DEBOUNCE_DIV out of range");
  end

  logic [7:0] dir_q, out_q, ie_q, ip_q, imode_lo_q, imode_hi_q;
  logic [7:0] sync1_q, sync2_q, prev_q;
  logic [7:0] filt, deben_rd, ip_set, ip_clr;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      ip_set[n] = pin_event(imode_e'({imode_hi_q[n], imode_lo_q[n]}), filt[n], prev_q[n]);
    end
  end

  assign ip_clr = (we && reg_a == REG_IP) ? di : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= '0;
      out_q      <= '0;
      ie_q       <= '0;
      ip_q       <= '0;
      imode_lo_q <= '0;
      imode_hi_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      prev_q  <= filt;
      // Set wins over a coincident write-1-to-clear.
      ip_q    <= (ip_q & ~ip_clr) | ip_set;
      if (we) begin
        case (reg_a)
          REG_DIR:      dir_q      <= di;
          REG_OUT:      out_q      <= di;
          REG_IE:       ie_q       <= di;
          REG_IMODE_LO: imode_lo_q <= di;
          REG_IMODE_HI: imode_hi_q <= di;
          default:      ;
        endcase
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_DIV);

  logic [CW-1:0] pre_cnt_q;
  logic [7:0]    deben_q, samp0_q, samp1_q, db_q, agree;
  logic          strobe;

  assign strobe = (pre_cnt_q == CW'(DEBOUNCE_DIV - 1));
  // A pin is accepted once the current sample matches the previous two.
  assign agree  = ~(samp0_q ^ sync2_q) & ~(samp1_q ^ sync2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      deben_q   <= '0;
      samp0_q   <= '0;
      samp1_q   <= '0;
      db_q      <= '0;
    end else begin
      pre_cnt_q <= strobe ? '0 : pre_cnt_q + 1'b1;
      if (strobe) begin
        samp0_q <= sync2_q;
        samp1_q <= samp0_q;
        db_q    <= (agree & sync2_q) | (~agree & db_q);
      end
      if (we && reg_a == REG_DEBEN) deben_q <= di;
    end
  end

  assign filt     = (deben_q & db_q) | (~deben_q & sync2_q);
  assign deben_rd = deben_q;
`else
  assign filt     = sync2_q;
  assign deben_rd = 8'h00;
`endif

  // NOTE: rdata gets a default before the case so no path can infer a latch.
  always_comb begin
    rdata = 8'h00;
    case (reg_a)
      REG_DIR:      rdata = dir_q;
      REG_OUT:      rdata = out_q;
      REG_IN:       rdata = filt;
      REG_IE:       rdata = ie_q;
      REG_IP:       rdata = ip_q;
      REG_IMODE_LO: rdata = imode_lo_q;
      REG_IMODE_HI: rdata = imode_hi_q;
      REG_DEBEN:    rdata = deben_rd;
      default:      rdata = 8'h00;
    endcase
  end

  assign out = out_q;
  assign oe  = dir_q;
  assign irq = |(ip_q & ie_q);

endmodule

// File: rtl/gpio_banked.sv
// Banked GPIO top: decodes the CSR bank field, muxes read data, ORs bank interrupts.
// Debounce filters are included when GPIO_DEBOUNCE_EN is defined.
module gpio_banked
  import gpio_pkg::*;
#(
  parameter int NUM_BANKS    = 1,
  parameter int DEBOUNCE_DIV = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             csr_a,
  input  logic [7:0]             csr_di,
  input  logic                   csr_we,
  output logic [7:0]             csr_do,
  input  logic [8*NUM_BANKS-1:0] in,
  output logic [8*NUM_BANKS-1:0] out,
  output logic [8*NUM_BANKS-1:0] oe,
  output logic                   irq
);

  if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_bad_banks
    $error("gpio_banked: NUM_BANKS out of range");
  end

  logic [1:0]           bank_sel;
  logic [7:0]           bank_rd [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_irq;

  assign bank_sel = csr_a[4:3];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    gpio_bank #(.DEBOUNCE_DIV(DEBOUNCE_DIV)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (csr_we && bank_sel == 2'(b)),
      .reg_a  (csr_a[2:0]),
      .di     (csr_di),
      .pin_in (in[8*b +: 8]),
      .rdata  (bank_rd[b]),
      .out    (out[8*b +: 8]),
      .oe     (oe[8*b +: 8]),
      .irq    (bank_irq[b])
    );
  end

  // Unpopulated banks fall through to zero.
  always_comb begin
    csr_do = 8'h00;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == 2'(b)) csr_do = bank_rd[b];
    end
  end

  assign irq = |bank_irq;

endmodule

// File: tb/tb_gpio_banked.sv
// Randomised bench for gpio_banked with a pad-history reference model and directed anchors.
module tb_gpio_banked;

  localparam int NB  = 2;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    csr_a;
  logic [7:0]    csr_di;
  logic          csr_we;
  logic [7:0]    csr_do;
  logic [8*NB-1:0] pad, out, oe;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  gpio_banked #(.NUM_BANKS(NB), .DEBOUNCE_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do),
    .in     (pad),
    .out    (out),
    .oe     (oe),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register file per bank plus a history of pad samples.
  // hist[k] is the pad value as it was sampled k+1 clock edges ago.
  logic [7:0]      m_dir[NB], m_out[NB], m_ie[NB], m_ip[NB], m_lo[NB], m_hi[NB], m_deben[NB];
  logic [8*NB-1:0] hist[3];

  function automatic logic mode_event(logic [1:0] m, logic cur, logic old);
    case (m)
      2'b00:   return cur && !old;
      2'b01:   return !cur && old;
      2'b10:   return cur != old;
      default: return cur;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        m_dir[b] = 0; m_out[b] = 0; m_ie[b] = 0; m_ip[b] = 0;
        m_lo[b] = 0;  m_hi[b] = 0;  m_deben[b] = 0;
      end
      for (int k = 0; k < 3; k++) hist[k] = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        logic [7:0] ev;
        for (int n = 0; n < 8; n++)
          ev[n] = mode_event({m_hi[b][n], m_lo[b][n]}, hist[1][8*b+n], hist[2][8*b+n]);
        if (csr_we && int'(csr_a[4:3]) == b && csr_a[2:0] == 3'd4) m_ip[b] = m_ip[b] & ~csr_di;
        m_ip[b] = m_ip[b] | ev;
        if (csr_we && int'(csr_a[4:3]) == b) begin
          case (csr_a[2:0])
            3'd0: m_dir[b] = csr_di;
            3'd1: m_out[b] = csr_di;
            3'd3: m_ie[b]  = csr_di;
            3'd5: m_lo[b]  = csr_di;
            3'd6: m_hi[b]  = csr_di;
`ifdef GPIO_DEBOUNCE_EN
            3'd7: m_deben[b] = csr_di;
`endif
            default: ;
          endcase
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pad;
    end
  end

  function automatic logic [7:0] m_read(logic [4:0] a);
    int b;
    b = int'(a[4:3]);
    if (b >= NB) return 8'h00;
    case (a[2:0])
      3'd0:    return m_dir[b];
      3'd1:    return m_out[b];
      3'd2:    return hist[1][8*b +: 8];
      3'd3:    return m_ie[b];
      3'd4:    return m_ip[b];
      3'd5:    return m_lo[b];
      3'd6:    return m_hi[b];
      default: return m_deben[b];
    endcase
  endfunction

  function automatic logic [8*NB-1:0] m_pins(bit want_oe);
    logic [8*NB-1:0] v;
    for (int b = 0; b < NB; b++) v[8*b +: 8] = want_oe ? m_dir[b] : m_out[b];
    return v;
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 1'b0;
    for (int b = 0; b < NB; b++) r = r | (|(m_ip[b] & m_ie[b]));
    return r;
  endfunction

  // Compare process: outputs are stable half a cycle after each input change.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_csr_do", 16'(csr_do), 16'(m_read(csr_a)));
      check("model_out",    16'(out),    16'(m_pins(1'b0)));
      check("model_oe",     16'(oe),     16'(m_pins(1'b1)));
      check("model_irq",    16'(irq),    16'(m_irq()));
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [4:0] a, logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic rd(logic [4:0] a, logic [7:0] exp, string name);
    csr_a = a;
    @(negedge clk);
    check(name, 16'(csr_do), 16'(exp));
    @(posedge clk); #1;
  endtask

  task automatic check_irq(logic exp, string name);
    @(negedge clk);
    check(name, 16'(irq), 16'(exp));
    @(posedge clk); #1;
  endtask

  // Reset with a coincident write that must be discarded.
  task automatic do_reset();
    pad = '0; csr_a = 5'd1; csr_di = 8'hFF; csr_we = 1'b1;
    rst = 1'b1;
    #1;
    check("reset_out", 16'(out), 16'h0000);
    check("reset_oe",  16'(oe),  16'h0000);
    check("reset_irq", 16'(irq), 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; csr_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pad = '0; csr_a = '0; csr_di = '0; csr_we = 1'b0;
    #1;
    do_reset();
    chk_en = 1'b1;

    // Register write reaches the pads the following cycle.
    rd(5'd0, 8'h00, "dir_after_reset");
    rd(5'd1, 8'h00, "out_after_reset");
    wr(5'd1, 8'hAA);
    wr(5'd0, 8'h0F);
    @(negedge clk);
    check("out_wr", 16'(out[7:0]), 16'h00AA);
    check("oe_wr",  16'(oe[7:0]),  16'h000F);
    @(posedge clk); #1;

    // Rising-edge capture and write-1-to-clear.
    wr(5'd3, 8'h10);
    pad[7:0] = 8'h20; idle(4);
    rd(5'd4, 8'h20, "ip_rise_pin5_no_ie");
    wr(5'd4, 8'h20);
    rd(5'd4, 8'h00, "ip_clear_pin5");
    pad[7:0] = 8'h30; idle(4);
    rd(5'd4, 8'h10, "ip_rise_pin4");
    check_irq(1'b1, "irq_set");
    wr(5'd4, 8'h10);
    rd(5'd4, 8'h00, "ip_w1c");
    check_irq(1'b0, "irq_clear");

    // Falling mode on pin0, both-edge mode on pin1.
    wr(5'd5, 8'h01);
    pad[7:0] = 8'h31; idle(4);
    rd(5'd4, 8'h00, "fall_mode_ignores_rise");
    pad[7:0] = 8'h30; idle(4);
    rd(5'd4, 8'h01, "fall_mode_fall");
    wr(5'd4, 8'hFF);
    wr(5'd6, 8'h02);
    pad[7:0] = 8'h32; idle(4);
    rd(5'd4, 8'h02, "both_mode_first");
    wr(5'd4, 8'h02);
    rd(5'd4, 8'h00, "both_mode_w1c");
    pad[7:0] = 8'h30; idle(4);
    rd(5'd4, 8'h02, "both_mode_second");

    // Second bank isolation and an unpopulated bank.
    do_reset();
    wr(5'h0B, 8'h01);
    pad = 16'h0100; idle(4);
    rd(5'h0C, 8'h01, "bank1_ip");
    rd(5'h04, 8'h00, "bank0_ip");
    check_irq(1'b1, "irq_bank1");
    wr(5'h18, 8'hFF);
    rd(5'h18, 8'h00, "bank3_read");
    rd(5'h08, 8'h00, "bank1_dir_untouched");

    // Level mode persists through W1C; set beats a coincident clear.
    do_reset();
    wr(5'd5, 8'h04);
    wr(5'd6, 8'h04);
    pad[7:0] = 8'h04; idle(4);
    rd(5'd4, 8'h04, "level_set");
    wr(5'd4, 8'h04);
    rd(5'd4, 8'h04, "level_w1c_no_effect");
    pad[7:0] = 8'h0C; idle(2);
    wr(5'd4, 8'h08);
    rd(5'd4, 8'h0C, "set_beats_clear");

`ifndef GPIO_DEBOUNCE_EN
    wr(5'd7, 8'hFF);
    rd(5'd7, 8'h00, "deben_absent");
`endif

    // Random traffic; DEBEN writes are steered away so the filter stays bypassed.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] a;
      a = 5'($urandom);
      if (a[2:0] == 3'd7) a[2:0] = 3'd3;
      csr_a  = a;
      csr_di = 8'($urandom);
      csr_we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) pad[$urandom_range(0, 8*NB-1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) pad = (8*NB)'($urandom);
      @(posedge clk); #1;
    end
    csr_we = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch rejected, sustained level accepted.
    chk_en = 1'b0;
    do_reset();
    wr(5'd7, 8'h01);
    rd(5'd7, 8'h01, "deben_readback");
    pad[0] = 1'b1; idle(5);
    pad[0] = 1'b0; idle(20);
    rd(5'd2, 8'h00, "debounce_glitch");
    pad[0] = 1'b1; idle(16);
    rd(5'd2, 8'h01, "debounce_stable");
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
